// File: rtl/axi2wb_pkg.sv
// Shared types and response codes for the AXI4-slave to Wishbone-classic bridge.
package axi2wb_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_DATA = 3'd1,
        S_WR_WB   = 3'd2,
        S_WR_RESP = 3'd3,
        S_RD_WB   = 3'd4,
        S_RD_DATA = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // A timeout outranks a slave error in the final write response.
    function automatic logic [1:0] wr_resp(input logic err, input logic dec);
        return dec ? RESP_DECERR : (err ? RESP_SLVERR : RESP_OKAY);
    endfunction

endpackage

// File: rtl/axi2wb_beat_ctr.sv
// Burst address/beat tracker: loads start address and length, steps one bus word per beat.
module axi2wb_beat_ctr #(
    parameter int ADDR_WIDTH = 32,
    parameter int SEL_WIDTH  = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [7:0]            len_i,
    input  logic                  step_i,
    output logic [ADDR_WIDTH-1:0] cur_addr_o,
    output logic                  is_last_o,
    output logic                  next_last_o
);

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [7:0]            beat_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            addr_q <= '0;
            len_q  <= '0;
            beat_q <= '0;
        end else if (load_i) begin
            addr_q <= addr_i;
            len_q  <= len_i;
            beat_q <= '0;
        end else if (step_i) begin
            // Plain wrap at the top of the address space; no 4KB boundary handling.
            addr_q <= addr_q + ADDR_WIDTH'(SEL_WIDTH);
            beat_q <= beat_q + 8'd1;
        end
    end

    assign cur_addr_o  = addr_q;
    assign is_last_o   = (beat_q == len_q);
    assign next_last_o = ((beat_q + 8'd1) == len_q);

endmodule

// File: rtl/axi_to_wb_bridge.sv
// AXI4 slave to Wishbone classic master, one beat per WB cycle, one transaction in flight.
// Optional AXI2WB_TIMEOUT_EN adds a WB ack timeout reported as DECERR.
module axi_to_wb_bridge
    import axi2wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SEL_WIDTH      = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [SEL_WIDTH-1:0]  s_axi_wstrb,
    input  logic                  s_axi_wlast,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    output logic [1:0]            s_axi_bresp,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    output logic                  wb_we_o,
    output logic [SEL_WIDTH-1:0]  wb_sel_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i
);

    state_e                state_q, state_d;
    logic                  last_wr_q, last_wr_d;
    logic                  err_q, err_d;
    logic                  dec_q, dec_d;
    logic                  cyc_q, cyc_d;
    logic                  stb_q, stb_d;
    logic                  we_q, we_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rlast_q, rlast_d;

    logic                  grant_wr, ctr_load, ctr_step, is_last, next_last, to_fire;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [7:0]            ld_len;
    logic                  unused_ok;

    // Round-robin: on a tie the channel not served last wins; reset state favours write.
    assign grant_wr = s_axi_awvalid && (!s_axi_arvalid || !last_wr_q);
    assign ld_addr  = grant_wr ? s_axi_awaddr : s_axi_araddr;
    assign ld_len   = grant_wr ? s_axi_awlen  : s_axi_arlen;

    axi2wb_beat_ctr #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_beat_ctr (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .load_i     (ctr_load),
        .addr_i     (ld_addr),
        .len_i      (ld_len),
        .step_i     (ctr_step),
        .cur_addr_o (wb_adr_o),
        .is_last_o  (is_last),
        .next_last_o(next_last)
    );

`ifdef AXI2WB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            to_cnt_q <= '0;
        else if (stb_q && !wb_ack_i && !wb_err_i)
            to_cnt_q <= to_cnt_q + TW'(1);
        else
            to_cnt_q <= '0;
    end

    // Fires on the last of TIMEOUT_CYCLES strobe cycles that saw no response.
    assign to_fire = stb_q && !wb_ack_i && !wb_err_i && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
    assign to_fire = 1'b0;
`endif

    assign unused_ok = s_axi_wlast ^ (TIMEOUT_CYCLES == 0);

    always_comb begin
        state_d       = state_q;
        last_wr_d     = last_wr_q;
        err_d         = err_q;
        dec_d         = dec_q;
        cyc_d         = cyc_q;
        stb_d         = stb_q;
        we_d          = we_q;
        sel_d         = sel_q;
        dat_d         = dat_q;
        bvalid_d      = bvalid_q;
        bresp_d       = bresp_q;
        rvalid_d      = rvalid_q;
        rdata_d       = rdata_q;
        rresp_d       = rresp_q;
        rlast_d       = rlast_q;
        ctr_load      = 1'b0;
        ctr_step      = 1'b0;
        s_axi_awready = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_wready  = 1'b0;

        case (state_q)
            S_IDLE: begin
                s_axi_awready = s_axi_awvalid && grant_wr;
                s_axi_arready = s_axi_arvalid && !grant_wr;
                if (s_axi_awvalid || s_axi_arvalid) begin
                    ctr_load  = 1'b1;
                    cyc_d     = 1'b1;
                    err_d     = 1'b0;
                    dec_d     = 1'b0;
                    last_wr_d = grant_wr;
                    if (grant_wr) begin
                        state_d = S_WR_DATA;
                    end else begin
                        stb_d   = 1'b1;
                        we_d    = 1'b0;
                        sel_d   = '1;
                        state_d = S_RD_WB;
                    end
                end
            end
            S_WR_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid) begin
                    if (err_q || dec_q) begin
                        ctr_step = 1'b1;
                        if (is_last) begin
                            cyc_d    = 1'b0;
                            we_d     = 1'b0;
                            bvalid_d = 1'b1;
                            bresp_d  = wr_resp(err_q, dec_q);
                            state_d  = S_WR_RESP;
                        end
                    end else begin
                        dat_d   = s_axi_wdata;
                        sel_d   = s_axi_wstrb;
                        we_d    = 1'b1;
                        stb_d   = 1'b1;
                        state_d = S_WR_WB;
                    end
                end
            end
            S_WR_WB: begin
                if (wb_ack_i || wb_err_i || to_fire) begin
                    stb_d    = 1'b0;
                    ctr_step = 1'b1;
                    if (!wb_ack_i && wb_err_i)
                        err_d = 1'b1;
                    if (to_fire) begin
                        dec_d = 1'b1;
                        cyc_d = 1'b0;
                    end
                    if (is_last) begin
                        cyc_d    = 1'b0;
                        we_d     = 1'b0;
                        bvalid_d = 1'b1;
                        bresp_d  = wr_resp(err_d, dec_d);
                        state_d  = S_WR_RESP;
                    end else begin
                        state_d = S_WR_DATA;
                    end
                end
            end
            S_WR_RESP: begin
                if (s_axi_bready) begin
                    bvalid_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            S_RD_WB: begin
                if (wb_ack_i || wb_err_i || to_fire) begin
                    stb_d    = 1'b0;
                    rvalid_d = 1'b1;
                    rlast_d  = is_last;
                    if (wb_ack_i) begin
                        rdata_d = wb_dat_i;
                        rresp_d = RESP_OKAY;
                    end else if (wb_err_i) begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_DECERR;
                        dec_d   = 1'b1;
                        cyc_d   = 1'b0;
                    end
                    if (is_last)
                        cyc_d = 1'b0;
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (s_axi_rready) begin
                    if (rlast_q) begin
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        ctr_step = 1'b1;
                        // After a timeout the rest of the burst is answered locally.
                        if (dec_q) begin
                            rdata_d = '0;
                            rresp_d = RESP_DECERR;
                            rlast_d = next_last;
                        end else begin
                            rvalid_d = 1'b0;
                            stb_d    = 1'b1;
                            state_d  = S_RD_WB;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            last_wr_q <= 1'b0;
            err_q     <= 1'b0;
            dec_q     <= 1'b0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            dat_q     <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            err_q     <= err_d;
            dec_q     <= dec_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            dat_q     <= dat_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    assign wb_cyc_o     = cyc_q;
    assign wb_stb_o     = stb_q;
    assign wb_we_o      = we_q;
    assign wb_sel_o     = sel_q;
    assign wb_dat_o     = dat_q;
    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rresp  = rresp_q;
    assign s_axi_rlast  = rlast_q;

endmodule

// File: doc/axi_to_wb_bridge.md
Name: axi_to_wb_bridge

Overview:
AXI4 slave to Wishbone classic master bridge, the inverse of the team's Wishbone-to-AXI adapter. It lets an AXI interconnect master reach legacy Wishbone peripherals. INCR bursts are split into one Wishbone classic cycle per beat. One transaction is outstanding at a time, with round-robin arbitration between the read and write channels.

Parameters:
ADDR_WIDTH, 32, AXI/WB address width
DATA_WIDTH, 32, data width (multiple of 8)
SEL_WIDTH, DATA_WIDTH/8, byte-strobe/select width
TIMEOUT_CYCLES, 255, WB ack timeout; used only with AXI2WB_TIMEOUT_EN

Ports:
wb_clk_i  in  1  clock; all logic rising-edge
wb_rst_i  in  1  reset, asynchronous, active-high
s_axi_awvalid/s_axi_awready  in/out  1  write address handshake
s_axi_awaddr  in  ADDR_WIDTH  write start address
s_axi_awlen  in  8  write beats minus 1
s_axi_wvalid/s_axi_wready  in/out  1  write data handshake
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  SEL_WIDTH  byte strobes
s_axi_wlast  in  1  last write beat (ignored; beat count governs)
s_axi_bvalid/s_axi_bready  out/in  1  write response handshake
s_axi_bresp  out  2  write response
s_axi_arvalid/s_axi_arready  in/out  1  read address handshake
s_axi_araddr  in  ADDR_WIDTH  read start address
s_axi_arlen  in  8  read beats minus 1
s_axi_rvalid/s_axi_rready  out/in  1  read data handshake
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  read response
s_axi_rlast  out  1  last read beat
wb_adr_o  out  ADDR_WIDTH  WB address
wb_dat_o  out  DATA_WIDTH  WB write data
wb_dat_i  in  DATA_WIDTH  WB read data
wb_we_o  out  1  WB write enable
wb_sel_o  out  SEL_WIDTH  WB byte select
wb_cyc_o  out  1  WB cycle
wb_stb_o  out  1  WB strobe
wb_ack_i  in  1  WB acknowledge
wb_err_i  in  1  WB error

Behaviour:
- Reset: every output is 0, state is IDLE, the arbiter favours write, and any in-flight burst is discarded without a response.
- States: IDLE, WR_DATA, WR_WB, WR_RESP, RD_WB, RD_DATA. All outputs are registered except awready, arready and wready.
- IDLE arbitration:
  - awready = awvalid && grant_wr; arready = arvalid && !grant_wr.
  - If only one valid is high, that channel is granted.
  - If both are high, grant is round-robin: the channel not served last wins. First win after reset is write.
- Address acceptance: on handshake, latch addr, len and beat counter = 0. Assert wb_cyc_o from the next cycle until the final beat's ack/err, held through the whole burst. Go to WR_DATA or RD_WB.
- WR_DATA:
  - wready=1.
  - On wvalid, latch wdata→wb_dat_o and wstrb→wb_sel_o, set wb_we_o=1 and wb_stb_o=1, go WR_WB.
  - If the error flag is already set, the beat is drained: no strobe is issued and the state returns straight to WR_DATA or WR_RESP.
- WR_WB:
  - Hold stb until wb_ack_i or wb_err_i; ack wins if both are high. On that cycle drop stb.
  - wb_err_i sets the sticky error flag.
  - Advance wb_adr_o by SEL_WIDTH (modulo 2^ADDR_WIDTH; no 4KB check).
  - If beat == len, drop cyc and go WR_RESP; otherwise beat++ and go WR_DATA.
- WR_RESP: bvalid=1, bresp = error ? 2'b10 (SLVERR) : 2'b00. Hold until bready, then IDLE.
- RD_WB:
  - stb=1, we=0, sel = all ones.
  - On ack, capture wb_dat_i into rdata with rresp=OKAY.
  - On err, rdata=0 and rresp=SLVERR.
  - Then drop stb and go RD_DATA. A read error does not abort the burst.
- RD_DATA:
  - rvalid=1; rlast=1 when beat == len.
  - Data and response are stable while rvalid && !rready.
  - On rready: if last, go IDLE (cyc already dropped); else advance address, beat++, go RD_WB.
- Latency:
  - Single write: AW handshake → stb 2 cycles later, assuming wvalid is already high.
  - Single read: AR handshake → stb next cycle; ack → rvalid next cycle.
- Throughput: a new address is not accepted until bvalid/rlast handshake completes.

Optional Feature:
AXI2WB_TIMEOUT_EN
- Defined: a counter runs while stb is high. If it reaches TIMEOUT_CYCLES without ack/err, drop stb and cyc and treat the beat as an error with response 2'b11 (DECERR).
  - Reads return rdata=0 and rresp=DECERR.
  - For writes, DECERR takes precedence over SLVERR in bresp.
  - Any remaining beats are drained/returned as DECERR without WB access.
- Undefined: no counter; the bridge waits indefinitely.

Decomposition:
- Package axi2wb_pkg: state enum (3 bits), RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
- Sub-module axi2wb_beat_ctr: loads addr/len, steps by SEL_WIDTH, outputs cur_addr and is_last.

Test Plan:
- Single write: addr 0x100, data 0xDEADBEEF, strb 4'b0011, ack after 2 cycles → one WB write with sel 0011, bresp=00.
- 4-beat write from 0x200 (awlen=3) → WB addresses 0x200/204/208/20C with cyc continuous, then one bvalid.
- 4-beat read from 0x300 with rready low for 3 cycles on beat 2 → rdata held stable, rlast only on beat 4, no extra stb.
- wb_err_i on beat 2 of a 4-beat write → beats 3-4 get no stb and bresp=10; wb_err_i on read beat 1 → rresp=10, rdata=0, later beats OKAY.
- awvalid and arvalid simultaneous twice → write served first, then read; reset asserted mid-read-burst → all outputs 0 and IDLE next edge.
- With AXI2WB_TIMEOUT_EN and TIMEOUT_CYCLES=8, WB never acks a read → stb drops after 8 cycles, rresp=11.
